// File: rtl/lsu_byte_sequencer_if.sv
// Request/response and data-memory bus for the LSU byte sequencer.
// The master side is the execute stage together with the memory; the slave side is the sequencer.
interface lsu_byte_sequencer_if #(
    parameter int AW   = 8,
    parameter int XLEN = 16
);
    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic            req_word;
    logic            req_signed;
    logic [AW-1:0]   req_addr;
    logic [XLEN-1:0] req_wdata;
    logic            resp_valid;
    logic [XLEN-1:0] resp_rdata;
    logic [AW-1:0]   mem_A;
    logic [7:0]      mem_D;
    logic            mem_DW;
    logic [7:0]      mem_RD;

    modport master (
        output req_valid, req_we, req_word, req_signed, req_addr, req_wdata, mem_RD,
        input  req_ready, resp_valid, resp_rdata, mem_A, mem_D, mem_DW
    );

    modport slave (
        input  req_valid, req_we, req_word, req_signed, req_addr, req_wdata, mem_RD,
        output req_ready, resp_valid, resp_rdata, mem_A, mem_D, mem_DW
    );
endinterface

// File: rtl/lsu_byte_sequencer.sv
// Splits 16-bit load/store requests into little-endian byte accesses on an 8-bit memory
// and returns zero/sign-extended load data with a one-cycle response pulse.
module lsu_byte_sequencer #(
    parameter int AW   = 8,
    parameter int XLEN = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    lsu_byte_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BYTE0 = 2'd1,
        S_BYTE1 = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next_state;

    logic            r_we;
    logic            r_word;
    logic            r_signed;
    logic [AW-1:0]   r_addr;
    logic [XLEN-1:0] r_wdata;
    logic [7:0]      r_byte0;

    logic [AW-1:0]   r_mem_a;
    logic [7:0]      r_mem_d;
    logic            r_mem_dw;
    logic            r_resp_valid;
    logic [XLEN-1:0] r_rdata;

    logic            w_accept;
    logic [AW-1:0]   w_mem_a_nx;
    logic [7:0]      w_mem_d_nx;
    logic            w_mem_dw_nx;
    logic [XLEN-1:0] w_rdata_nx;
    logic            w_byte0_cap;

    assign w_accept       = bus.req_valid && (r_state == S_IDLE);
    assign bus.req_ready  = (r_state == S_IDLE) && !rst;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_rdata = r_rdata;
    assign bus.mem_A      = r_mem_a;
    assign bus.mem_D      = r_mem_d;
    assign bus.mem_DW     = r_mem_dw;

    // Next-state decode.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next_state = S_BYTE0;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_BYTE0: begin
                if (r_word) begin
                    w_next_state = S_BYTE1;
                end else begin
                    w_next_state = S_RESP;
                end
            end
            S_BYTE1: w_next_state = S_RESP;
            S_RESP:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Memory-side outputs are registered one edge ahead, so they hold their last value when idle.
    always_comb begin
        w_mem_a_nx  = r_mem_a;
        w_mem_d_nx  = r_mem_d;
        w_mem_dw_nx = 1'b0;
        w_rdata_nx  = r_rdata;
        w_byte0_cap = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_mem_a_nx  = bus.req_addr;
                    w_mem_d_nx  = bus.req_wdata[7:0];
                    w_mem_dw_nx = bus.req_we;
                end else begin
                    w_mem_dw_nx = 1'b0;
                end
            end
            S_BYTE0: begin
                if (r_word) begin
                    w_mem_a_nx  = r_addr + {{(AW-1){1'b0}}, 1'b1};
                    w_mem_d_nx  = r_wdata[15:8];
                    w_mem_dw_nx = r_we;
                    w_byte0_cap = !r_we;
                end else if (!r_we) begin
                    w_rdata_nx  = {{8{bus.mem_RD[7] & r_signed}}, bus.mem_RD};
                end else begin
                    w_rdata_nx  = r_rdata;
                end
            end
            S_BYTE1: begin
                if (!r_we) begin
                    w_rdata_nx = {bus.mem_RD, r_byte0};
                end else begin
                    w_rdata_nx = r_rdata;
                end
            end
            S_RESP:  w_mem_dw_nx = 1'b0;
            default: w_mem_dw_nx = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Request latch; inputs are ignored once the access is in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we     <= 1'b0;
            r_word   <= 1'b0;
            r_signed <= 1'b0;
            r_addr   <= {AW{1'b0}};
            r_wdata  <= {XLEN{1'b0}};
        end else if (w_accept) begin
            r_we     <= bus.req_we;
            r_word   <= bus.req_word;
            r_signed <= bus.req_signed;
            r_addr   <= bus.req_addr;
            r_wdata  <= bus.req_wdata;
        end
    end

    // Output and load-data registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_a      <= {AW{1'b0}};
            r_mem_d      <= 8'h00;
            r_mem_dw     <= 1'b0;
            r_resp_valid <= 1'b0;
            r_rdata      <= {XLEN{1'b0}};
            r_byte0      <= 8'h00;
        end else begin
            r_mem_a      <= w_mem_a_nx;
            r_mem_d      <= w_mem_d_nx;
            r_mem_dw     <= w_mem_dw_nx;
            r_resp_valid <= (w_next_state == S_RESP);
            r_rdata      <= w_rdata_nx;
            if (w_byte0_cap) begin
                r_byte0 <= bus.mem_RD;
            end
        end
    end
endmodule

// File: tb/tb_lsu_byte_sequencer.sv
// Directed bench for lsu_byte_sequencer with a 256x8 behavioural data memory.
module tb_lsu_byte_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_vec  = 0;
    int   n_miss = 0;
    int   dw_cnt = 0;
    int   lat;
    int   dw_snap;
    logic [7:0] mem [256];

    always #5 clk = ~clk;

    lsu_byte_sequencer_if #(.AW(8), .XLEN(16)) bus ();

    lsu_byte_sequencer #(.AW(8), .XLEN(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.mem_RD = mem[bus.mem_A];

    // Memory: preset each byte to addr^A5, then synchronous write on DW.
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;
        forever begin
            @(posedge clk);
            if (bus.mem_DW === 1'b1) begin
                mem[bus.mem_A] <= bus.mem_D;
                dw_cnt++;
            end
        end
    end

    task automatic chk_vec(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic set_req(input logic we, input logic word, input logic sgn,
                           input logic [7:0] addr, input logic [15:0] wdata);
        bus.req_we     = we;
        bus.req_word   = word;
        bus.req_signed = sgn;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
    endtask

    task automatic wait_ready();
        int t = 0;
        while (bus.req_ready !== 1'b1 && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        chk_vec("ready_wait", bus.req_ready, 16'h0001);
    endtask

    // Issue one request; returns the cycle index of resp_valid (accept-edge cycle = 1), left in RESP.
    task automatic issue(input logic we, input logic word, input logic sgn,
                         input logic [7:0] addr, input logic [15:0] wdata, output int l);
        set_req(we, word, sgn, addr, wdata);
        bus.req_valid = 1'b1;
        wait_ready();
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        l = 1;
        while (bus.resp_valid !== 1'b1 && l < 10) begin
            @(posedge clk); #1;
            l++;
        end
    endtask

    initial begin
        bus.req_valid = 1'b0;
        set_req(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);

        // Reset state
        #1 rst = 1'b1;
        #1;
        chk_vec("rst_ready", bus.req_ready, 16'h0000);
        chk_vec("rst_rvalid", bus.resp_valid, 16'h0000);
        chk_vec("rst_rdata", bus.resp_rdata, 16'h0000);
        chk_vec("rst_memA", bus.mem_A, 16'h0000);
        chk_vec("rst_memD", bus.mem_D, 16'h0000);
        chk_vec("rst_memDW", bus.mem_DW, 16'h0000);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1 chk_vec("rel_ready", bus.req_ready, 16'h0001);

        // Word store then load
        issue(1'b1, 1'b1, 1'b0, 8'h10, 16'hBEEF, lat);
        chk_vec("wst_lat", 16'(lat), 16'd3);
        chk_vec("wst_m10", mem[8'h10], 16'h00EF);
        chk_vec("wst_m11", mem[8'h11], 16'h00BE);
        chk_vec("wst_rdata", bus.resp_rdata, 16'h0000);
        issue(1'b0, 1'b1, 1'b0, 8'h10, 16'h0000, lat);
        chk_vec("wld_lat", 16'(lat), 16'd3);
        chk_vec("wld_rdata", bus.resp_rdata, 16'hBEEF);

        // Byte sign handling
        issue(1'b1, 1'b0, 1'b0, 8'h20, 16'h7785, lat);
        chk_vec("bst_lat", 16'(lat), 16'd2);
        chk_vec("bst_m20", mem[8'h20], 16'h0085);
        chk_vec("bst_m21", mem[8'h21], 16'h0084);
        issue(1'b0, 1'b0, 1'b1, 8'h20, 16'h0000, lat);
        chk_vec("bld_s_lat", 16'(lat), 16'd2);
        chk_vec("bld_s_rdata", bus.resp_rdata, 16'hFF85);
        issue(1'b0, 1'b0, 1'b0, 8'h20, 16'h0000, lat);
        chk_vec("bld_u_lat", 16'(lat), 16'd2);
        chk_vec("bld_u_rdata", bus.resp_rdata, 16'h0085);

        // Wrap-around
        issue(1'b1, 1'b1, 1'b0, 8'hFF, 16'h1234, lat);
        chk_vec("wrap_mFF", mem[8'hFF], 16'h0034);
        chk_vec("wrap_m00", mem[8'h00], 16'h0012);
        issue(1'b0, 1'b1, 1'b0, 8'hFF, 16'h0000, lat);
        chk_vec("wrap_rdata", bus.resp_rdata, 16'h1234);
        chk_vec("wrap_memA_hold", bus.mem_A, 16'h0000);
        chk_vec("wrap_dw_resp", bus.mem_DW, 16'h0000);

        // Back-to-back with req_valid held high
        @(posedge clk); #1;
        set_req(1'b0, 1'b1, 1'b0, 8'h10, 16'h0000);
        bus.req_valid = 1'b1;
        wait_ready();
        @(posedge clk); #1;
        set_req(1'b1, 1'b0, 1'b0, 8'h50, 16'hDEAD);
        chk_vec("b2b_b0_ready", bus.req_ready, 16'h0000);
        chk_vec("b2b_b0_memA", bus.mem_A, 16'h0010);
        chk_vec("b2b_b0_dw", bus.mem_DW, 16'h0000);
        @(posedge clk); #1;
        chk_vec("b2b_b1_ready", bus.req_ready, 16'h0000);
        chk_vec("b2b_b1_memA", bus.mem_A, 16'h0011);
        @(posedge clk); #1;
        chk_vec("b2b_resp_ready", bus.req_ready, 16'h0000);
        chk_vec("b2b_resp_valid", bus.resp_valid, 16'h0001);
        chk_vec("b2b_resp_rdata", bus.resp_rdata, 16'hBEEF);
        @(posedge clk); #1;
        chk_vec("b2b_idle_ready", bus.req_ready, 16'h0001);
        chk_vec("b2b_idle_rvalid", bus.resp_valid, 16'h0000);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk_vec("b2b_2nd_dw", bus.mem_DW, 16'h0001);
        chk_vec("b2b_2nd_memA", bus.mem_A, 16'h0050);
        chk_vec("b2b_2nd_memD", bus.mem_D, 16'h00AD);
        @(posedge clk); #1;
        chk_vec("b2b_2nd_resp", bus.resp_valid, 16'h0001);
        chk_vec("b2b_2nd_rdata", bus.resp_rdata, 16'hBEEF);
        chk_vec("b2b_m50", mem[8'h50], 16'h00AD);
        chk_vec("b2b_m51", mem[8'h51], 16'h00F4);

        // Store leaves read data; one write cycle for a byte store
        issue(1'b0, 1'b1, 1'b0, 8'h10, 16'h0000, lat);
        chk_vec("keep_ld", bus.resp_rdata, 16'hBEEF);
        dw_snap = dw_cnt;
        issue(1'b1, 1'b0, 1'b0, 8'h30, 16'h0055, lat);
        @(posedge clk); #1;
        chk_vec("keep_dw_cycles", 16'(dw_cnt - dw_snap), 16'd1);
        chk_vec("keep_rdata", bus.resp_rdata, 16'hBEEF);
        chk_vec("keep_m30", mem[8'h30], 16'h0055);

        // Reset during BYTE1 of a word store
        set_req(1'b1, 1'b1, 1'b0, 8'h40, 16'hA1B2);
        bus.req_valid = 1'b1;
        wait_ready();
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk_vec("rmid_b0_memA", bus.mem_A, 16'h0040);
        @(posedge clk); #1;
        chk_vec("rmid_b1_dw", bus.mem_DW, 16'h0001);
        chk_vec("rmid_b1_memD", bus.mem_D, 16'h00A1);
        #2 rst = 1'b1;
        #1;
        chk_vec("rmid_dw", bus.mem_DW, 16'h0000);
        chk_vec("rmid_memA", bus.mem_A, 16'h0000);
        chk_vec("rmid_memD", bus.mem_D, 16'h0000);
        chk_vec("rmid_rdata", bus.resp_rdata, 16'h0000);
        chk_vec("rmid_rvalid", bus.resp_valid, 16'h0000);
        chk_vec("rmid_ready", bus.req_ready, 16'h0000);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk_vec("rmid_rel_ready", bus.req_ready, 16'h0001);
        chk_vec("rmid_m40", mem[8'h40], 16'h00B2);
        chk_vec("rmid_m41", mem[8'h41], 16'h00E4);
        issue(1'b0, 1'b0, 1'b0, 8'h41, 16'h0000, lat);
        chk_vec("post_rst_lat", 16'(lat), 16'd2);
        chk_vec("post_rst_rdata", bus.resp_rdata, 16'h00E4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/lsu_byte_sequencer.md
Name: lsu_byte_sequencer

Overview:
- Load/store sequencer directly upstream of the 8-bit data memory (256 x 8, synchronous write on clk when DW, combinational read RD = mem[A]).
- Accepts 16-bit-datapath load/store requests from the execute stage and splits each word access into two sequential byte accesses, little-endian.
- Returns load data, zero- or sign-extended, through a one-cycle response pulse.

Parameters:
- AW, 8, memory address width; addresses wrap modulo 2^AW.
- XLEN, 16, request and response data width; fixed at 2x the 8-bit memory byte.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  sequencer can accept; high only in IDLE.
- req_we  input  1  1 = store, 0 = load.
- req_word  input  1  1 = 16-bit access, 0 = byte access.
- req_signed  input  1  byte load only: 1 = sign-extend, 0 = zero-extend.
- req_addr  input  AW  byte address; any alignment.
- req_wdata  input  XLEN  store data; a byte store uses [7:0].
- resp_valid  output  1  one-cycle completion pulse, for loads and stores.
- resp_rdata  output  XLEN  load result.
- mem_A  output  AW  address to data memory.
- mem_D  output  8  write data to data memory.
- mem_DW  output  1  write enable to data memory.
- mem_RD  input  8  combinational read data from data memory.

Behaviour:
- Handshake: a request is accepted on a rising edge when req_valid && req_ready. All request fields are latched at acceptance; inputs are ignored afterwards. There is no response backpressure.
- FSM states: IDLE, BYTE0, BYTE1, RESP.
  - IDLE -> BYTE0 on accept.
  - BYTE0 -> BYTE1 if word, otherwise -> RESP.
  - BYTE1 -> RESP.
  - RESP -> IDLE unconditionally.
- BYTE0 cycle: mem_A = addr_q, mem_D = wdata_q[7:0], mem_DW = we_q. On a load, mem_RD is captured into the low byte on the closing edge.
- BYTE1 cycle: mem_A = addr_q + 1 (AW-bit wrap, 0xFF -> 0x00), mem_D = wdata_q[15:8], mem_DW = we_q. On a load, mem_RD is captured into the high byte.
- mem_DW is 0 in IDLE and RESP. mem_A and mem_D hold their last driven values in IDLE and RESP.
- resp_valid is 1 only in RESP.
  - Latency from the accept edge to resp_valid: byte access 2 cycles, word access 3 cycles.
  - Maximum throughput: one byte op per 3 cycles, one word op per 4 cycles. req_ready returns high in the cycle after RESP.
- resp_rdata is registered and updated only by loads; stores leave it unchanged.
  - Word load: {byte1, byte0}.
  - Byte load: {8{byte0[7] & signed_q}, byte0}.
  - resp_rdata is stable from RESP until the next load's RESP.
- Read-after-write: a load accepted immediately after a store's RESP observes the stored data, because the memory write has completed.
- Reset (asynchronous, any state): FSM -> IDLE, resp_valid = 0, resp_rdata = 0x0000, mem_A = 0, mem_D = 0, mem_DW = 0, latched request cleared.
  - Reset between BYTE0 and BYTE1 of a word store leaves the low byte written and the high byte unwritten. This is accepted behaviour; no rollback.
- req_ready is 0 during reset assertion and is 1 in the first cycle after deassertion.

Test Plan:
- Word store then load: store addr 0x10, wdata 0xBEEF, then load word at 0x10 -> mem[0x10]=0xEF, mem[0x11]=0xBE; load resp_rdata = 0xBEEF, resp_valid 3 cycles after its accept edge.
- Byte sign handling: store byte 0x85 at 0x20. Load byte with signed=1 -> 0xFF85. Load byte with signed=0 -> 0x0085. Each resp_valid is 2 cycles after accept.
- Wrap-around: word store 0x1234 at 0xFF -> mem[0xFF]=0x34, mem[0x00]=0x12; word load at 0xFF -> 0x1234.
- Back-to-back requests with req_valid held high: req_ready low during BYTE0, BYTE1 and RESP. The second request is accepted only in the cycle after RESP. Fields changed mid-operation do not affect the in-flight access.
- Store leaves read data: load word 0xBEEF, then store byte 0x55 at 0x30 -> resp_rdata still 0xBEEF after the store's RESP; mem_DW high exactly one cycle.
- Reset mid-word-store: store 0xA1B2 at 0x40 with rst asserted asynchronously during BYTE1 before the edge -> mem[0x40]=0xB2, mem[0x41] unchanged. Outputs are at reset values immediately, and req_ready=1 in the first cycle after rst deasserts.
